// File: rtl/pixel_stream_packer_pkg.sv
// Shared types and defaults for the pixel stream packer.
//   pack_mode_e  : output word layout (packed RGB888 or XRGB)
//   pack_word_t  : one FIFO entry, {tdata, tlast, tuser}
//   phase_e      : RGB888 packing phase (pixel position within a 4-pixel group)
package pixel_stream_packer_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int COLOR_WIDTH   = 8;

  typedef enum logic {
    PACK_RGB888 = 1'b0,
    PACK_XRGB   = 1'b1
  } pack_mode_e;

  typedef struct packed {
    logic [31:0] tdata;
    logic        tlast;
    logic        tuser;
  } pack_word_t;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented on rd_data
// whenever the FIFO is non-empty; rd_data reads as zero when empty.
//   aclk, aresetn : clock, async active-low reset (clears pointers/count)
//   push, wr_data : write request and data (ignored when full)
//   pop           : consume head entry (ignored when empty)
//   rd_data       : head entry
//   full, empty   : occupancy flags
module stream_fifo
  import pixel_stream_packer_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Zero when empty so the stream data bus is quiet after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs r/g/b pixels into a 32-bit AXI4-Stream of words.
//   aclk, aresetn        : clock, async active-low reset
//   restart              : synchronous frame restart (x, y, phase, residue)
//   r, g, b              : pixel channels, COLOR_WIDTH bits each
//   in_valid, in_ready   : pixel handshake
//   out_stream_*         : AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   frame_count          : completed frames, wraps
//
// state | meaning
// PH0   | next pixel starts a 4-pixel group; it is stored, nothing pushed
// PH1   | 3 residue bytes held; next pixel completes word 0 of the group
// PH2   | 2 residue bytes held; next pixel completes word 1
// PH3   | 1 residue byte held; next pixel completes word 2
module pixel_stream_packer #(
  parameter int H_RES       = pixel_stream_packer_pkg::SCREEN_WIDTH,
  parameter int V_RES       = pixel_stream_packer_pkg::SCREEN_HEIGHT,
  parameter int COLOR_WIDTH = pixel_stream_packer_pkg::COLOR_WIDTH,
  parameter int PIXEL_MODE  = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   restart,
  input  logic [COLOR_WIDTH-1:0] r,
  input  logic [COLOR_WIDTH-1:0] g,
  input  logic [COLOR_WIDTH-1:0] b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [31:0]            out_stream_tdata,
  output logic [3:0]             out_stream_tkeep,
  output logic                   out_stream_tlast,
  output logic                   out_stream_tuser,
  output logic                   out_stream_tvalid,
  input  logic                   out_stream_tready,
  output logic [15:0]            frame_count
);
  import pixel_stream_packer_pkg::*;

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam pack_mode_e MODE = (PIXEL_MODE == 1) ? PACK_XRGB : PACK_RGB888;

  logic [7:0]    r8, g8, b8;
  phase_e        phase, phase_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [23:0]   residue;
  logic [1:0]    ready_sh;
  logic          accept, push, fifo_full, fifo_empty, x_last, y_last;
  pack_word_t    push_word, head_word;

  generate
    if (COLOR_WIDTH >= 8) begin : g_trunc
      assign r8 = r[COLOR_WIDTH-1 -: 8];
      assign g8 = g[COLOR_WIDTH-1 -: 8];
      assign b8 = b[COLOR_WIDTH-1 -: 8];
      if (COLOR_WIDTH > 8) begin : g_lsbs
        logic unused_lsbs;
        assign unused_lsbs = ^{r[COLOR_WIDTH-9:0], g[COLOR_WIDTH-9:0], b[COLOR_WIDTH-9:0]};
      end
    end else begin : g_expand
      // Left-align and repeat the channel pattern so full scale maps to 8'hFF.
      always_comb begin
        r8 = '0;
        g8 = '0;
        b8 = '0;
        for (int i = 0; i < 8; i++) begin
          r8[7-i] = r[COLOR_WIDTH-1-(i % COLOR_WIDTH)];
          g8[7-i] = g[COLOR_WIDTH-1-(i % COLOR_WIDTH)];
          b8[7-i] = b[COLOR_WIDTH-1-(i % COLOR_WIDTH)];
        end
      end
    end
  endgenerate

  // ready_sh keeps in_ready low through the first edge after reset release.
  assign in_ready = ready_sh[1] & ~fifo_full & ~restart;
  assign accept   = in_valid & in_ready;
  assign x_last   = (x == XW'(H_RES - 1));
  assign y_last   = (y == YW'(V_RES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) phase <= PH0;
    else          phase <= phase_nxt;
  end

  // Residue bytes sit in stream order: residue[7:0] is the oldest byte.
  always_comb begin
    phase_nxt = phase;
    push      = 1'b0;
    push_word = '0;
    if (MODE == PACK_XRGB) begin
      push            = accept;
      push_word.tdata = {8'h00, b8, g8, r8};
      push_word.tuser = (x == '0) && (y == '0);
      push_word.tlast = x_last;
    end else begin
      case (phase)
        PH1: begin
          push_word.tdata = {r8, residue};
          // Group started at x=0; the completing pixel sits at x=1.
          push_word.tuser = (x == XW'(1)) && (y == '0);
        end
        PH2: push_word.tdata = {g8, r8, residue[15:0]};
        PH3: begin
          push_word.tdata = {b8, g8, r8, residue[7:0]};
          push_word.tlast = x_last;
        end
        default: ;
      endcase
      push = accept && (phase != PH0);
      if (accept) begin
        case (phase)
          PH0:     phase_nxt = PH1;
          PH1:     phase_nxt = PH2;
          PH2:     phase_nxt = PH3;
          default: phase_nxt = PH0;
        endcase
      end
    end
    if (restart) phase_nxt = PH0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x           <= '0;
      y           <= '0;
      residue     <= '0;
      frame_count <= '0;
      ready_sh    <= '0;
    end else begin
      ready_sh <= {ready_sh[0], 1'b1};
      if (restart) begin
        x       <= '0;
        y       <= '0;
        residue <= '0;
      end else if (accept) begin
        if (x_last) begin
          x <= '0;
          if (y_last) begin
            y           <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
        case (phase)
          PH0:     residue <= {b8, g8, r8};
          PH1:     residue <= {8'h00, b8, g8};
          PH2:     residue <= {16'h0000, b8};
          default: residue <= '0;
        endcase
      end
    end
  end

  stream_fifo #(
    .WIDTH($bits(pack_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .aresetn(aresetn),
    .push   (push),
    .wr_data(push_word),
    .pop    (out_stream_tvalid & out_stream_tready),
    .rd_data(head_word),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_stream_tvalid = ~fifo_empty;
  assign out_stream_tdata  = head_word.tdata;
  assign out_stream_tlast  = head_word.tlast;
  assign out_stream_tuser  = head_word.tuser;
  assign out_stream_tkeep  = 4'hF;

endmodule
